// File: rtl/fib_lookup_pkg.sv
// ---------------------------------------------------------------------------
// fib_lookup_pkg
// Shared definitions for the forwarding-information-base lookup engine:
// port count, MAC / port-number widths, the I/G bit position, the FSM
// state encoding, the table entry layout and the table index hash.
// ---------------------------------------------------------------------------
package fib_lookup_pkg;

  localparam int NUM_PORTS = 4;
  localparam int MAC_W     = 48;
  localparam int PORT_W    = 4;
  localparam int IG_BIT    = 40;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_RESULT = 2'd3
  } fib_state_t;

  typedef struct packed {
    logic              valid;
    logic [MAC_W-1:0]  mac;
    logic [PORT_W-1:0] port;
  } fib_entry_t;

  localparam int ENTRY_W = $bits(fib_entry_t);

  // XOR fold of the MAC into asz-bit chunks. Bit i of the MAC lands on
  // bit (i mod asz) of the index, which is the same as XORing successive
  // chunks with the last partial chunk zero-extended. Only the low asz
  // bits of the result are meaningful; callers cast down to their width.
  function automatic logic [MAC_W-1:0] fib_hash(input logic [MAC_W-1:0] mac,
                                                input int               asz);
    logic [MAC_W-1:0] h;
    h = '0;
    for (int i = 0; i < MAC_W; i++) begin
      h[i % asz] = h[i % asz] ^ mac[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/fib_lookup_mem.sv
// ---------------------------------------------------------------------------
// fib_mem
// Single-port synchronous RAM holding the forwarding table, 2^asz entries
// of dw bits. Read-first: a write and a read to the same address in one
// cycle return the old contents. Behavioural; a vendor macro can replace it.
//
// Ports
//   clk      : clock
//   i_we     : write enable
//   i_addr   : read / write address
//   i_wdata  : write data
//   o_rdata  : registered read data (contents of i_addr one cycle earlier)
// ---------------------------------------------------------------------------
module fib_mem
  import fib_lookup_pkg::*;
#(
  parameter int asz = 8,
  parameter int dw  = ENTRY_W
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [asz-1:0] i_addr,
  input  logic [dw-1:0]  i_wdata,
  output logic [dw-1:0]  o_rdata
);

  logic [dw-1:0] r_mem [0:(1<<asz)-1];

  // Storage array with read-first behaviour; no reset because the
  // engine clears every entry itself after reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/fib_lookup.sv
// ---------------------------------------------------------------------------
// fib_lookup
// Forwarding-information-base lookup engine. Accepts a lookup request
// (DA, SA, source port), learns SA -> port in a direct-mapped table,
// looks up the DA and returns a destination port mask to the requesting
// tap on that tap's fli srdy/drdy channel.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   lpi_srdy/lpi_drdy : lookup request handshake
//   lpi_da, lpi_sa    : destination / source MAC of the request
//   lpi_port          : source port number of the request
//   fli_srdy          : per-tap result valid (one-hot on the source port)
//   fli_drdy          : per-tap result accept (only the source bit matters)
//   fli_data          : destination port mask, shared by all taps
// ---------------------------------------------------------------------------
module fib_lookup
  import fib_lookup_pkg::*;
#(
  parameter int num_ports = NUM_PORTS,
  parameter int asz       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lpi_srdy,
  output logic                 lpi_drdy,
  input  logic [MAC_W-1:0]     lpi_da,
  input  logic [MAC_W-1:0]     lpi_sa,
  input  logic [PORT_W-1:0]    lpi_port,
  output logic [num_ports-1:0] fli_srdy,
  input  logic [num_ports-1:0] fli_drdy,
  output logic [num_ports-1:0] fli_data
);

  typedef logic [asz-1:0] addr_t;

  fib_state_t            r_state;
  fib_state_t            w_nextState;
  addr_t                 r_initAddr;
  logic [MAC_W-1:0]      r_da;
  logic [MAC_W-1:0]      r_sa;
  logic [PORT_W-1:0]     r_src;
  logic [num_ports-1:0]  r_mask;

  addr_t                 w_daIdx;
  addr_t                 w_saIdx;
  addr_t                 w_memAddr;
  logic                  w_memWe;
  logic [ENTRY_W-1:0]    w_memWdata;
  logic [ENTRY_W-1:0]    w_memRdata;
  fib_entry_t            w_entry;

  logic                  w_srcValid;
  logic                  w_srcDrdy;
  logic                  w_learn;
  logic [num_ports-1:0]  w_flood;
  logic [num_ports-1:0]  w_entryOneHot;
  logic [num_ports-1:0]  w_srcOneHot;
  logic [num_ports-1:0]  w_lookupMask;

  assign w_daIdx    = addr_t'(fib_hash(lpi_da, asz));
  assign w_saIdx    = addr_t'(fib_hash(r_sa, asz));
  assign w_entry    = fib_entry_t'(w_memRdata);
  assign w_srcValid = ({1'b0, r_src} < (PORT_W+1)'(num_ports));
  assign w_learn    = w_srcValid && !r_sa[IG_BIT];

  fib_mem #(
    .asz (asz),
    .dw  (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_addr  (w_memAddr),
    .i_wdata (w_memWdata),
    .o_rdata (w_memRdata)
  );

  // Port-indexed helper vectors. Comparing against each port number keeps
  // an out-of-range source from ever indexing past the mask width.
  always_comb begin
    w_flood       = '0;
    w_entryOneHot = '0;
    w_srcOneHot   = '0;
    w_srcDrdy     = 1'b0;
    for (int i = 0; i < num_ports; i++) begin
      w_flood[i]       = (r_src != PORT_W'(i));
      w_entryOneHot[i] = (w_entry.port == PORT_W'(i));
      w_srcOneHot[i]   = (r_src == PORT_W'(i));
      if (r_src == PORT_W'(i)) begin
        w_srcDrdy = fli_drdy[i];
      end
    end
  end

  // Destination mask from the table entry read at hash(DA). Multicast DA
  // and misses flood; a hit on the source's own port filters the frame.
  // An unknown source port yields all-ones.
  always_comb begin
    w_lookupMask = w_flood;
    if (!w_srcValid) begin
      w_lookupMask = '1;
    end else if (r_da[IG_BIT]) begin
      w_lookupMask = w_flood;
    end else if (w_entry.valid && (w_entry.mac == r_da)) begin
      w_lookupMask = (w_entry.port == r_src) ? '0 : w_entryOneHot;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. INIT runs until the last table address has been
  // cleared; LOOKUP skips RESULT when the source port is unknown.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_INIT:   if (r_initAddr == '1) w_nextState = ST_IDLE;
      ST_IDLE:   if (lpi_srdy)         w_nextState = ST_LOOKUP;
      ST_LOOKUP: w_nextState = w_srcValid ? ST_RESULT : ST_IDLE;
      ST_RESULT: if (w_srcDrdy)        w_nextState = ST_IDLE;
      default:   w_nextState = ST_INIT;
    endcase
  end

  // Output and memory control. IDLE reads at hash(lpi_da) so the entry is
  // available in LOOKUP, where the learn write goes to hash(SA); the RAM
  // is read-first so the lookup always sees pre-learn contents.
  always_comb begin
    lpi_drdy   = 1'b0;
    fli_srdy   = '0;
    w_memAddr  = w_daIdx;
    w_memWe    = 1'b0;
    w_memWdata = '0;
    case (r_state)
      ST_INIT: begin
        w_memAddr = r_initAddr;
        w_memWe   = 1'b1;
      end
      ST_IDLE: begin
        lpi_drdy = 1'b1;
      end
      ST_LOOKUP: begin
        w_memAddr  = w_saIdx;
        w_memWe    = w_learn;
        w_memWdata = {1'b1, r_sa, r_src};
      end
      ST_RESULT: begin
        if (w_srcValid) begin
          fli_srdy = w_srcOneHot;
        end
      end
      default: begin
        lpi_drdy = 1'b0;
      end
    endcase
  end

  // Datapath registers: init sweep address, latched request and the
  // result mask, which only changes at the end of LOOKUP so it is stable
  // for as long as the tap stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_initAddr <= '0;
      r_da       <= '0;
      r_sa       <= '0;
      r_src      <= '0;
      r_mask     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_initAddr <= r_initAddr + 1'b1;
        end
        ST_IDLE: begin
          if (lpi_srdy) begin
            r_da  <= lpi_da;
            r_sa  <= lpi_sa;
            r_src <= lpi_port;
          end
        end
        ST_LOOKUP: begin
          r_mask <= w_lookupMask;
        end
        default: begin
          r_mask <= r_mask;
        end
      endcase
    end
  end

  assign fli_data = r_mask;

endmodule

// File: tb/tb_fib_lookup.sv
// ---------------------------------------------------------------------------
// tb_fib_lookup
// Self-checking bench for fib_lookup (num_ports=4, asz=8). A table model
// indexed by a byte-wise XOR hash predicts every result; a per-cycle
// monitor compares lpi_drdy, fli_srdy and fli_data against the expected
// values that the driver updates as each request moves through the engine.
// ---------------------------------------------------------------------------
module tb_fib_lookup;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        lpi_srdy = 1'b0;
  logic        lpi_drdy;
  logic [47:0] lpi_da   = '0;
  logic [47:0] lpi_sa   = '0;
  logic [3:0]  lpi_port = '0;
  logic [3:0]  fli_srdy;
  logic [3:0]  fli_drdy = 4'hf;
  logic [3:0]  fli_data;

  int total = 0;
  int bad   = 0;

  bit         monEn   = 1'b0;
  logic       expDrdy = 1'b0;
  logic [3:0] expSrdy = '0;
  logic [3:0] expData = '0;

  bit          mValid [256];
  logic [47:0] mMac   [256];
  logic [3:0]  mPort  [256];

  logic [3:0]  gotSrdy;
  logic [3:0]  gotData;
  logic [47:0] pool [12];

  fib_lookup #(
    .num_ports (4),
    .asz       (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lpi_srdy (lpi_srdy),
    .lpi_drdy (lpi_drdy),
    .lpi_da   (lpi_da),
    .lpi_sa   (lpi_sa),
    .lpi_port (lpi_port),
    .fli_srdy (fli_srdy),
    .fli_drdy (fli_drdy),
    .fli_data (fli_data)
  );

  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Byte-wise XOR of the MAC: the table index for an 8-bit address.
  function automatic logic [7:0] bhash(input logic [47:0] mac);
    logic [47:0] t;
    logic [7:0]  h;
    t = mac;
    h = '0;
    while (t != 0) begin
      h = h ^ t[7:0];
      t = t >> 8;
    end
    return h;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
  endtask

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("mon_lpi_drdy", lpi_drdy, expDrdy);
      checkOutput("mon_fli_srdy", fli_srdy, expSrdy);
      checkOutput("mon_fli_data", fli_data, expData);
    end
  end

  // Counts cycles with lpi_drdy low after reset has been released.
  task automatic runInit();
    int cnt;
    cnt = 0;
    while (!lpi_drdy && cnt < 400) begin
      cnt++;
      @(posedge clk); #1;
    end
    checkOutput("init_len", cnt, 256);
    expDrdy = 1'b1;
  endtask

  // Issues one request and walks the expectations through LOOKUP/RESULT.
  task automatic applyStimulus(input logic [47:0] da, input logic [47:0] sa,
                               input logic [3:0] port, input int stall,
                               input logic [3:0] stray, input bit midReset);
    int         n;
    logic [3:0] mask;
    logic [3:0] flood;
    logic [7:0] idx;
    n = 0;
    while (!lpi_drdy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    if (!lpi_drdy) begin
      checkOutput("req_wait_timeout", 0, 1);
      return;
    end
    lpi_da   = da;
    lpi_sa   = sa;
    lpi_port = port;
    lpi_srdy = 1'b1;

    flood = 4'hf & ~(4'b0001 << port);
    if (port >= 4) begin
      mask = 4'hf;
    end else begin
      idx = bhash(da);
      if (da[40]) mask = flood;
      else if (mValid[idx] && mMac[idx] == da)
        mask = (mPort[idx] == port) ? 4'h0 : (4'b0001 << mPort[idx]);
      else mask = flood;
      if (!sa[40]) begin
        idx = bhash(sa);
        mValid[idx] = 1'b1;
        mMac[idx]   = sa;
        mPort[idx]  = port;
      end
    end

    @(posedge clk); #1;
    lpi_srdy = 1'b0;
    expDrdy  = 1'b0;
    @(posedge clk); #1;
    expData = mask;
    gotSrdy = fli_srdy;
    gotData = fli_data;
    if (port < 4) begin
      expSrdy = 4'b0001 << port;
      if (midReset) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        expSrdy = '0;
        expData = '0;
        clearModel();
        checkOutput("rst_fli_srdy", fli_srdy, 0);
        runInit();
        return;
      end
      if (stall > 0) begin
        fli_drdy = stray & ~(4'b0001 << port);
        repeat (stall) begin
          @(posedge clk); #1;
        end
      end
      fli_drdy = 4'hf;
      @(posedge clk); #1;
      expSrdy = '0;
      expDrdy = 1'b1;
    end else begin
      expDrdy = 1'b1;
    end
  endtask

  initial begin
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lpi_drdy", lpi_drdy, 0);
    checkOutput("rst_fli_srdy0", fli_srdy, 0);
    checkOutput("rst_fli_data", fli_data, 0);
    reset = 1'b0;
    monEn = 1'b1;
    runInit();

    // Unknown DA floods.
    applyStimulus(48'h2, 48'h1, 4'd1, 0, 4'h0, 1'b0);
    checkOutput("tp_unknown_srdy", gotSrdy, 4'b0010);
    checkOutput("tp_unknown_data", gotData, 4'b1101);

    // DA learned on port 1.
    applyStimulus(48'h1, 48'h2, 4'd3, 0, 4'h0, 1'b0);
    checkOutput("tp_learned_srdy", gotSrdy, 4'b1000);
    checkOutput("tp_learned_data", gotData, 4'b0010);

    // Filter: DA lives on the requesting port.
    applyStimulus(48'h1, 48'h3, 4'd1, 0, 4'h0, 1'b0);
    checkOutput("tp_filter_data", gotData, 4'b0000);

    // Broadcast DA.
    applyStimulus(48'hffff_ffff_ffff, 48'h4, 4'd0, 0, 4'h0, 1'b0);
    checkOutput("tp_bcast_data", gotData, 4'b1110);

    // Multicast SA is not learned; its MAC later floods.
    applyStimulus(48'h7, 48'h0100_0000_0009, 4'd2, 0, 4'h0, 1'b0);
    checkOutput("tp_mcsa_data", gotData, 4'b1011);
    applyStimulus(48'h0100_0000_0009, 48'ha, 4'd0, 0, 4'h0, 1'b0);
    checkOutput("tp_mcda_data", gotData, 4'b1110);

    // Backpressure on tap 2 with a stray accept on tap 0.
    applyStimulus(48'h1, 48'hb, 4'd2, 10, 4'b0001, 1'b0);
    checkOutput("tp_stall_srdy", gotSrdy, 4'b0100);
    checkOutput("tp_stall_data", gotData, 4'b0010);

    // Unknown source port.
    applyStimulus(48'h1, 48'h0c0c, 4'd5, 0, 4'h0, 1'b0);
    checkOutput("tp_badport_srdy", gotSrdy, 4'b0000);
    checkOutput("tp_badport_data", gotData, 4'b1111);

    // Collision: 12:34 and 34:12 share an index; the second overwrites.
    applyStimulus(48'hff, 48'h1234, 4'd1, 0, 4'h0, 1'b0);
    applyStimulus(48'hfe, 48'h3412, 4'd3, 0, 4'h0, 1'b0);
    applyStimulus(48'h1234, 48'hd, 4'd0, 0, 4'h0, 1'b0);
    checkOutput("tp_coll_first", gotData, 4'b1110);
    applyStimulus(48'h3412, 48'he, 4'd0, 0, 4'h0, 1'b0);
    checkOutput("tp_coll_second", gotData, 4'b1000);

    // Randomised traffic over a small MAC pool so hits and collisions occur.
    for (int i = 0; i < 10; i++) begin
      pool[i] = {16'($urandom), 32'($urandom)};
      pool[i][40] = ($urandom_range(0, 3) == 0);
    end
    pool[10] = 48'h1234;
    pool[11] = 48'h3412;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)],
                    4'($urandom_range(0, 4)), $urandom_range(0, 3),
                    4'($urandom_range(0, 15)), 1'b0);
    end

    // Reset while a result is pending wipes the table.
    applyStimulus(48'h2, 48'h1, 4'd1, 0, 4'h0, 1'b0);
    applyStimulus(48'h5, 48'h6, 4'd0, 0, 4'h0, 1'b1);
    applyStimulus(48'h1, 48'h8, 4'd3, 0, 4'h0, 1'b0);
    checkOutput("tp_wiped_data", gotData, 4'b0111);

    repeat (2) @(posedge clk);
    #1;
    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
